alu_input_frontend: RTL
=======================

// Module: alu_input_frontend
// PURPOSE
//  Upstream/downstream partner of the ALU display top: consumes lcd_module touch input
//  (input_valid/input_value) plus the input_sel switches, holds ALU operands/control,
//  and serves the lcd_module display_number poll with registered name/value lines.
//  Adds a commit counter and an optional ring buffer of recent ALU results.
// PARAMETERS
//  DEBOUNCE_CYCLES  10000  cycles input_sel must stay stable before it is accepted (1 ms @ 10 MHz)
//  HIST_DEPTH       8      history ring entries; power of 2, 2..16
//  COUNT_W          16     width of commit counter
// PORTS
//  clk             in   1   system clock (10 MHz)
//  reset           in   1   synchronous, active-high reset
//  input_sel       in   2   raw switches: 00 CONTROL, 01 COMMIT, 10 SRC1, 11 SRC2
//  input_valid     in   1   lcd_module input strobe (level; edge-detected here)
//  input_value     in   32  lcd_module entered value
//  alu_result      in   32  combinational ALU result for current operands
//  display_number  in   6   line index polled by lcd_module
//  alu_control     out  4   ALU opcode register
//  alu_src1        out  32  operand 1 register
//  alu_src2        out  32  operand 2 register
//  display_valid   out  1   line valid
//  display_name    out  40  5 ASCII chars
//  display_value   out  32  line value
// BEHAVIOUR
//  Reset: alu_control/src1/src2=0, display_*=0, sel_stable=00, counter=0, ring ptr/fill=0, iv_d=1.
//  Sel path: 2-FF synchroniser -> debouncer; sel_stable updates when synced value differs
//   for DEBOUNCE_CYCLES consecutive cycles; any return to sel_stable clears the count.
//  Strobe: load = input_valid & ~iv_d (rising edge). iv_d=1 at reset, so a level held high
//   through reset never triggers a load.
//  On load (1-cycle effect, next clk): 00 -> alu_control<=input_value[3:0];
//   10 -> alu_src1<=input_value; 11 -> alu_src2<=input_value;
//   01 -> commit: hist[wr_ptr]<=alu_result, wr_ptr++ (mod HIST_DEPTH),
//   fill=min(fill+1,HIST_DEPTH), commit_count++ saturating at 2^COUNT_W-1. input_value ignored.
//  Sel change and strobe same cycle: strobe uses the old sel_stable.
//  Display: registered, latency 1 cycle from display_number to outputs.
//   1 "SRC_1" src1 | 2 "SRC_2" src2 | 3 "CONTR" {28'd0,control} | 4 "RESUL" alu_result
//   5 "COUNT" zero-extended commit_count
//   6..5+HIST_DEPTH: "HIS_"+ASCII(k), k=number-6; k=0 newest = hist[wr_ptr-1-k];
//    valid only if k<fill, else display_valid=0, name=0, value=0.
//   others (incl. 0): display_valid=0, name=0, value=0.
//  Commit and display read of history same cycle: display shows pre-commit contents.
//  Reset mid-operation: all state cleared next edge; in-progress debounce discarded.
// CONFIGURATION
//  ALU_HISTORY_EN defined: ring buffer, fill, and lines 6..5+HIST_DEPTH present.
//  Undefined: no ring storage; commit only increments commit_count; lines >=6 invalid.
// STRUCTURE
//  alu_display_pkg: SEL_CONTROL/SEL_COMMIT/SEL_SRC1/SEL_SRC2 codes, LINE_* indices,
//   NAME_* 40-bit ASCII constants, HIST_LINE_BASE=6.
//  Sub-module sel_debouncer (sync + stability counter, param WIDTH, CYCLES).
// TESTING
//  1 Reset with input_valid=1 held -> no register loads; all outputs 0; COUNT line = 0.
//  2 sel=10 (after debounce), strobe 0x12345678; poll line 1 -> next cycle valid, "SRC_1", 0x12345678.
//  3 sel glitch 10->11 for DEBOUNCE_CYCLES-1 cycles then back; strobe 0xAA -> loads SRC1, not SRC2.
//  4 control=0 (ADD), src1=3, src2=4, sel=01, 10 commits -> line 5 value 10; line 6 "HIS_0" = 7.
//  5 ALU_HISTORY_EN, HIST_DEPTH=8: 9 commits with results 1..9 -> line 6=9, line 13=2; 3 commits only -> line 9 invalid.
//  6 Line 6 polled in same cycle as commit -> shows previous newest; next poll shows new result.

Source files
------------

// File: rtl/alu_display_pkg.sv
// Shared definitions for the ALU input front end: switch codes for input_sel,
// display line indices, and the 5-character ASCII line names.
package alu_display_pkg;

  // input_sel switch codes.
  typedef enum logic [1:0] {
    SEL_CONTROL = 2'b00,
    SEL_COMMIT  = 2'b01,
    SEL_SRC1    = 2'b10,
    SEL_SRC2    = 2'b11
  } sel_t;

  // Display line indices polled by lcd_module.
  localparam logic [5:0] LINE_SRC1      = 6'd1;
  localparam logic [5:0] LINE_SRC2      = 6'd2;
  localparam logic [5:0] LINE_CONTROL   = 6'd3;
  localparam logic [5:0] LINE_RESULT    = 6'd4;
  localparam logic [5:0] LINE_COUNT     = 6'd5;
  localparam logic [5:0] HIST_LINE_BASE = 6'd6;

  // Line names, first character in the most significant byte.
  localparam logic [39:0] NAME_SRC1       = "SRC_1";
  localparam logic [39:0] NAME_SRC2       = "SRC_2";
  localparam logic [39:0] NAME_CONTROL    = "CONTR";
  localparam logic [39:0] NAME_RESULT     = "RESUL";
  localparam logic [39:0] NAME_COUNT      = "COUNT";
  localparam logic [31:0] NAME_HIS_PREFIX = "HIS_";

  // One display line as it is presented to lcd_module.
  typedef struct packed {
    logic        valid;
    logic [39:0] name;
    logic [31:0] value;
  } line_t;

  localparam line_t LINE_NONE = '{valid: 1'b0, name: 40'd0, value: 32'd0};

  // ASCII character for a history slot number (0-9, then A-F).
  function automatic logic [7:0] hex_char(input logic [3:0] k);
    return (k < 4'd10) ? (8'h30 + {4'h0, k}) : (8'h37 + {4'h0, k});
  endfunction

endpackage

// File: rtl/alu_input_frontend_if.sv
// Bus between lcd_module / ALU and the input front end. The slave modport is
// the front end's view, the master modport is the environment driving it.
interface alu_input_frontend_if;

  logic [1:0]  input_sel;
  logic        input_valid;
  logic [31:0] input_value;
  logic [31:0] alu_result;
  logic [5:0]  display_number;
  logic [3:0]  alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;

  modport slave (
    input  input_sel, input_valid, input_value, alu_result, display_number,
    output alu_control, alu_src1, alu_src2,
           display_valid, display_name, display_value
  );

  modport master (
    output input_sel, input_valid, input_value, alu_result, display_number,
    input  alu_control, alu_src1, alu_src2,
           display_valid, display_name, display_value
  );

endinterface

// File: rtl/alu_input_frontend_sel_debouncer.sv
// Two-flop synchroniser followed by a stability counter. The stable output
// only moves once the synchronised value has differed from it for CYCLES
// consecutive clocks; any return to the stable value restarts the count.
module sel_debouncer #(
  parameter int WIDTH  = 2,
  parameter int CYCLES = 10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [CNT_W-1:0] count;

  // Bring the asynchronous switches into the clock domain.
  // NOTE: non-blocking assignments make sync_q2 take the old sync_q1, giving
  // two real flops; blocking here would collapse the chain into one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new value only after it has held for CYCLES clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      count  <= '0;
    end else if (sync_q2 == stable) begin
      count <= '0;
    end else if (count == LAST) begin
      stable <= sync_q2;
      count  <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_input_frontend.sv
// ALU input front end: takes lcd_module touch entries steered by the debounced
// input_sel switches into the ALU operand/control registers, counts commits,
// and answers the display_number poll with a registered name/value line.
// Build option: define ALU_HISTORY_EN to add a ring buffer of committed ALU
// results, shown on lines 6..5+HIST_DEPTH (newest first).
module alu_input_frontend
  import alu_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int HIST_DEPTH      = 8,
  parameter int COUNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_input_frontend_if.slave  bus
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  if (HIST_DEPTH < 2 || HIST_DEPTH > 16 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("HIST_DEPTH must be a power of two between 2 and 16");
  end
  if (COUNT_W < 1 || COUNT_W > 32) begin : g_bad_count_w
    $error("COUNT_W must be between 1 and 32");
  end

  logic [1:0]         sel_bits;
  sel_t               sel_stable;
  logic               iv_d;
  logic               load;
  logic               commit;
  logic [3:0]         control_q;
  logic [31:0]        src1_q;
  logic [31:0]        src2_q;
  logic [COUNT_W-1:0] commit_count;
  line_t              line_next;
  line_t              line_q;

  sel_debouncer #(
    .WIDTH  (2),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sel_debouncer (
    .clk    (clk),
    .reset  (reset),
    .raw    (bus.input_sel),
    .stable (sel_bits)
  );

  assign sel_stable = sel_t'(sel_bits);

  // Rising edge of the strobe. iv_d comes out of reset high so a strobe that
  // is already high when reset drops is not mistaken for a new entry.
  assign load   = bus.input_valid & ~iv_d;
  assign commit = load && (sel_stable == SEL_COMMIT);

  // Delay the strobe by one clock for edge detection.
  always_ff @(posedge clk) begin
    if (reset) iv_d <= 1'b1;
    else       iv_d <= bus.input_valid;
  end

  // Steer an entered value into the register selected by the switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      control_q <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
    end else if (load) begin
      case (sel_stable)
        SEL_CONTROL: control_q <= bus.input_value[3:0];
        SEL_SRC1:    src1_q    <= bus.input_value;
        SEL_SRC2:    src2_q    <= bus.input_value;
        default:     ;
      endcase
    end
  end

  // Count commits, holding at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset)                                commit_count <= '0;
    else if (commit && commit_count != COUNT_MAX) commit_count <= commit_count + COUNT_W'(1);
  end

  assign bus.alu_control = control_q;
  assign bus.alu_src1    = src1_q;
  assign bus.alu_src2    = src2_q;

`ifdef ALU_HISTORY_EN
  localparam int PTR_W  = $clog2(HIST_DEPTH);
  localparam int FILL_W = $clog2(HIST_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HIST_DEPTH);

  logic [31:0]       hist [HIST_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [FILL_W-1:0] fill;
  logic [5:0]        hist_k;
  logic [PTR_W-1:0]  rd_idx;
  logic              hist_hit;

  // Capture the ALU result on each commit.
  // NOTE: the ring storage has no reset; fill says which slots hold real
  // results, so the array can map onto plain RAM without a clear port.
  always_ff @(posedge clk) begin
    if (commit) hist[wr_ptr] <= bus.alu_result;
  end

  // Advance the write pointer and grow the fill level up to the depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (commit) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
    end
  end

  // Slot k counts back from the newest entry, which sits just below wr_ptr.
  assign hist_k   = bus.display_number - HIST_LINE_BASE;
  assign rd_idx   = wr_ptr - PTR_W'(1) - hist_k[PTR_W-1:0];
  assign hist_hit = (bus.display_number >= HIST_LINE_BASE) &&
                    (hist_k < 6'(HIST_DEPTH)) &&
                    (hist_k < 6'(fill));
`endif

  // Select the line for the polled index; unknown or empty lines read as zero.
  // NOTE: line_next gets its default before the case so that every path
  // assigns it and no latch is inferred.
  always_comb begin
    line_next = LINE_NONE;
    case (bus.display_number)
      LINE_SRC1:    line_next = '{1'b1, NAME_SRC1,    src1_q};
      LINE_SRC2:    line_next = '{1'b1, NAME_SRC2,    src2_q};
      LINE_CONTROL: line_next = '{1'b1, NAME_CONTROL, {28'd0, control_q}};
      LINE_RESULT:  line_next = '{1'b1, NAME_RESULT,  bus.alu_result};
      LINE_COUNT:   line_next = '{1'b1, NAME_COUNT,   32'(commit_count)};
      default: begin
`ifdef ALU_HISTORY_EN
        if (hist_hit) begin
          line_next = '{1'b1, {NAME_HIS_PREFIX, hex_char(hist_k[3:0])}, hist[rd_idx]};
        end
`endif
      end
    endcase
  end

  // Register the display line; it reads state from before any same-cycle commit.
  always_ff @(posedge clk) begin
    if (reset) line_q <= LINE_NONE;
    else       line_q <= line_next;
  end

  assign bus.display_valid = line_q.valid;
  assign bus.display_name  = line_q.name;
  assign bus.display_value = line_q.value;

endmodule
